// File: rtl/ap_pkg.sv
// ============================================================================
// Module      : ap_pkg
// Description : Shared mode encoding and default 10 kHz tick constants for the
//               autopilot mode controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ap_pkg;

    typedef enum logic [1:0] {
        AP_INIT     = 2'd0,
        AP_NORMAL   = 2'd1,
        AP_HOLD     = 2'd2,
        AP_FAILSAFE = 2'd3
    } ap_mode_t;

    // Defaults at the 10 kHz tick: 50 ms, 1 s and 200 ms.
    localparam int c_STABLE_TICKS  = 500;
    localparam int c_HOLD_TICKS    = 10000;
    localparam int c_RECOVER_TICKS = 2000;

endpackage

`default_nettype wire

// File: rtl/ap_ch_debounce.sv
// ============================================================================
// Module      : ap_ch_debounce
// Description : Single-channel level debouncer; a differing clean level must
//               persist STABLE_TICKS cycles before it is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ap_ch_debounce #(
    parameter int   STABLE_TICKS = 500,
    parameter logic RST_VAL      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic clear,
    input  logic enable,
    input  logic rx_problem,
    input  logic log_in,
    input  logic load,
    input  logic load_val,
    output logic ch_out
);

    localparam int DW = $clog2(STABLE_TICKS + 1);

    logic [DW-1:0] r_cnt;
    logic          w_cond;
    logic          w_done;

    assign w_cond = enable && !rx_problem && (log_in != ch_out);
    assign w_done = (r_cnt == DW'(STABLE_TICKS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            ch_out <= RST_VAL;
        end else if (load) begin
            r_cnt  <= '0;
            ch_out <= load_val;
        end else if (clear || !active || !w_cond) begin
            r_cnt <= '0;
        end else if (w_done) begin
            r_cnt  <= '0;
            ch_out <= log_in;
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ap_mode_ctrl.sv
// ============================================================================
// Module      : ap_mode_ctrl
// Description : Receiver-health supervisor sequencing INIT/NORMAL/HOLD/FAILSAFE
//               and debouncing the servo channel bits. Optional macro
//               AP_FAILSAFE_DEFAULTS_EN forces FAILSAFE_VALUE in FAILSAFE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ap_mode_ctrl
    import ap_pkg::*;
#(
    parameter int             NCH            = 4,
    parameter int             STABLE_TICKS   = c_STABLE_TICKS,
    parameter int             HOLD_TICKS     = c_HOLD_TICKS,
    parameter int             RECOVER_TICKS  = c_RECOVER_TICKS,
    parameter logic [NCH-1:0] FAILSAFE_VALUE = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] ch_log,
    input  logic [NCH-1:0] ch_rx_problem,
    input  logic [NCH-1:0] ch_enable,
    output logic [NCH-1:0] ch_out,
    output logic           failsafe,
    output ap_mode_t       mode,
    output logic           mode_change
);

    localparam int c_TMAX = (HOLD_TICKS > RECOVER_TICKS) ? HOLD_TICKS : RECOVER_TICKS;
    localparam int TW     = $clog2(c_TMAX + 1);

    ap_mode_t      r_state;
    logic [TW-1:0] r_timer;
    logic          w_any_problem;
    logic          w_active;
    logic          w_hold_done;
    logic          w_rec_done;
    logic          w_enter_fs;
    logic          w_load;
    logic [TW-1:0] w_timer_inc;

    assign w_any_problem = |(ch_rx_problem & ch_enable);
    assign w_active      = (r_state == AP_NORMAL) && !w_any_problem;
    assign w_hold_done   = (r_timer == TW'(HOLD_TICKS - 1));
    assign w_rec_done    = (r_timer == TW'(RECOVER_TICKS - 1));
    assign w_enter_fs    = (r_state == AP_HOLD) && w_any_problem && w_hold_done;
    assign w_timer_inc   = (r_timer == '1) ? r_timer : r_timer + 1'b1;
    assign mode          = r_state;

`ifdef AP_FAILSAFE_DEFAULTS_EN
    assign w_load = w_enter_fs || (r_state == AP_FAILSAFE);
`else
    assign w_load = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= AP_INIT;
            r_timer     <= '0;
            failsafe    <= 1'b1;
            mode_change <= 1'b0;
        end else begin
            mode_change <= 1'b0;
            case (r_state)
                AP_INIT, AP_FAILSAFE: begin
                    if (w_any_problem) begin
                        r_timer <= '0;
                    end else if (w_rec_done) begin
                        r_state     <= AP_NORMAL;
                        r_timer     <= '0;
                        failsafe    <= 1'b0;
                        mode_change <= 1'b1;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                AP_NORMAL: begin
                    if (w_any_problem) begin
                        r_state     <= AP_HOLD;
                        r_timer     <= '0;
                        mode_change <= 1'b1;
                    end
                end
                AP_HOLD: begin
                    if (!w_any_problem) begin
                        r_state     <= AP_NORMAL;
                        r_timer     <= '0;
                        mode_change <= 1'b1;
                    end else if (w_enter_fs) begin
                        r_state     <= AP_FAILSAFE;
                        r_timer     <= '0;
                        failsafe    <= 1'b1;
                        mode_change <= 1'b1;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                default: begin
                    r_state  <= AP_INIT;
                    r_timer  <= '0;
                    failsafe <= 1'b1;
                end
            endcase
        end
    end

    // Debounce only runs in NORMAL on problem-free cycles; everything else clears it.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ap_ch_debounce #(
            .STABLE_TICKS (STABLE_TICKS),
            .RST_VAL      (FAILSAFE_VALUE[i])
        ) u_deb (
            .clk        (clk),
            .rst_n      (rst_n),
            .active     (w_active),
            .clear      (!w_active),
            .enable     (ch_enable[i]),
            .rx_problem (ch_rx_problem[i]),
            .log_in     (ch_log[i]),
            .load       (w_load),
            .load_val   (FAILSAFE_VALUE[i]),
            .ch_out     (ch_out[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_ap_mode_ctrl.sv
// ============================================================================
// Module      : tb_ap_mode_ctrl
// Description : Directed bench for ap_mode_ctrl with a cycle-level reference
//               model and hand-computed checkpoints.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ap_mode_ctrl;
    import ap_pkg::*;

    localparam int             NCH = 4;
    localparam int             STB = 5;
    localparam int             HLD = 20;
    localparam int             REC = 10;
    localparam logic [NCH-1:0] FSV = 4'b0000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] ch_log = '0;
    logic [NCH-1:0] ch_rx_problem = '0;
    logic [NCH-1:0] ch_enable = 4'b1111;
    logic [NCH-1:0] ch_out;
    logic           failsafe;
    ap_mode_t       mode;
    logic           mode_change;

    int vectors = 0;
    int miscompares = 0;

    ap_mode_ctrl #(
        .NCH(NCH), .STABLE_TICKS(STB), .HOLD_TICKS(HLD),
        .RECOVER_TICKS(REC), .FAILSAFE_VALUE(FSV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_log(ch_log), .ch_rx_problem(ch_rx_problem),
        .ch_enable(ch_enable), .ch_out(ch_out), .failsafe(failsafe),
        .mode(mode), .mode_change(mode_change)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks how long the current condition has lasted.
    ap_mode_t       m_mode;
    int             m_run;
    int             m_pend [NCH];
    logic [NCH-1:0] m_out;
    logic           m_fs;
    logic           m_chg;

    always @(posedge clk or negedge rst_n) begin : model
        ap_mode_t       nxt;
        int             run;
        int             pend [NCH];
        logic [NCH-1:0] outv;
        bit             prob;
        if (!rst_n) begin
            m_mode <= AP_INIT;
            m_run  <= 0;
            for (int i = 0; i < NCH; i++) m_pend[i] <= 0;
            m_out  <= FSV;
            m_fs   <= 1'b1;
            m_chg  <= 1'b0;
        end else begin
            prob = |(ch_rx_problem & ch_enable);
            nxt  = m_mode;
            run  = m_run;
            pend = m_pend;
            outv = m_out;
            if (m_mode == AP_INIT || m_mode == AP_FAILSAFE) begin
                run = prob ? 0 : run + 1;
                if (run == REC) nxt = AP_NORMAL;
            end else if (m_mode == AP_NORMAL) begin
                if (prob) nxt = AP_HOLD;
                else begin
                    for (int i = 0; i < NCH; i++) begin
                        if (ch_enable[i] && !ch_rx_problem[i] && ch_log[i] != outv[i]) begin
                            pend[i] = pend[i] + 1;
                            if (pend[i] == STB) begin
                                outv[i] = ch_log[i];
                                pend[i] = 0;
                            end
                        end else pend[i] = 0;
                    end
                end
            end else begin
                if (!prob) nxt = AP_NORMAL;
                else begin
                    run = run + 1;
                    if (run == HLD) nxt = AP_FAILSAFE;
                end
            end
            if (nxt != m_mode) begin
                run = 0;
                for (int i = 0; i < NCH; i++) pend[i] = 0;
`ifdef AP_FAILSAFE_DEFAULTS_EN
                if (nxt == AP_FAILSAFE) outv = FSV;
`endif
            end
            m_chg  <= (nxt != m_mode);
            m_mode <= nxt;
            m_fs   <= (nxt == AP_INIT || nxt == AP_FAILSAFE);
            m_run  <= run;
            m_pend <= pend;
            m_out  <= outv;
        end
    end

    always @(negedge clk) begin
        check("mode", 32'(mode), 32'(m_mode));
        check("failsafe", 32'(failsafe), 32'(m_fs));
        check("mode_change", 32'(mode_change), 32'(m_chg));
        check("ch_out", 32'(ch_out), 32'(m_out));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns the number of negedges until mode equals target (0 on timeout).
    task automatic wait_mode(input ap_mode_t target, input int limit, output int n);
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (mode == target) begin
                n = i;
                break;
            end
        end
    endtask

    logic [NCH-1:0] exp_fs_out;
    int n;
    int h;

    initial begin
`ifdef AP_FAILSAFE_DEFAULTS_EN
        exp_fs_out = 4'b0000;
`else
        exp_fs_out = 4'b0100;
`endif
        cyc(2);
        check("rst_mode", 32'(mode), 32'(AP_INIT));
        check("rst_failsafe", 32'(failsafe), 32'd1);
        check("rst_mode_change", 32'(mode_change), 32'd0);
        check("rst_ch_out", 32'(ch_out), 32'h0);
        rst_n = 1'b1;

        // Clean start
        wait_mode(AP_NORMAL, 30, n);
        check("clean_start_cycles", n, 10);
        check("clean_start_pulse", 32'(mode_change), 32'd1);
        check("clean_start_fs", 32'(failsafe), 32'd0);
        cyc(1);
        check("clean_start_pulse_end", 32'(mode_change), 32'd0);

        // Debounce: 4 cycles rejected, 5 accepted
        ch_log[2] = 1'b1;
        cyc(4);
        ch_log[2] = 1'b0;
        check("deb_short", 32'(ch_out), 32'h0);
        cyc(2);
        ch_log[2] = 1'b1;
        cyc(4);
        check("deb_edge4", 32'(ch_out), 32'h0);
        cyc(1);
        check("deb_edge5", 32'(ch_out), 32'h4);

        // Glitch
        ch_rx_problem[1] = 1'b1;
        cyc(1);
        check("glitch_hold", 32'(mode), 32'(AP_HOLD));
        cyc(2);
        ch_rx_problem[1] = 1'b0;
        cyc(1);
        check("glitch_normal", 32'(mode), 32'(AP_NORMAL));
        check("glitch_fs", 32'(failsafe), 32'd0);
        check("glitch_out", 32'(ch_out), 32'h4);

        // Failsafe entry
        ch_rx_problem[0] = 1'b1;
        cyc(1);
        check("fs_hold_entry", 32'(mode), 32'(AP_HOLD));
        h = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mode != AP_HOLD) break;
            h++;
        end
        check("hold_cycles", h, 20);
        check("fs_mode", 32'(mode), 32'(AP_FAILSAFE));
        check("fs_flag", 32'(failsafe), 32'd1);
        check("fs_ch_out", 32'(ch_out), 32'(exp_fs_out));

        // Recovery restart
        ch_rx_problem[0] = 1'b0;
        cyc(7);
        ch_rx_problem[0] = 1'b1;
        cyc(1);
        ch_rx_problem[0] = 1'b0;
        check("recover_still_fs", 32'(mode), 32'(AP_FAILSAFE));
        wait_mode(AP_NORMAL, 30, n);
        check("recover_cycles", n, 10);
        cyc(8);

        // Enable drop mid-debounce restarts the count
        ch_log[1] = 1'b1;
        cyc(3);
        ch_enable[1] = 1'b0;
        cyc(1);
        ch_enable[1] = 1'b1;
        cyc(4);
        check("en_drop_edge4", 32'(ch_out[1]), 32'd0);
        cyc(1);
        check("en_drop_edge5", 32'(ch_out[1]), 32'd1);

        // Masking
        ch_enable[3] = 1'b0;
        ch_rx_problem[3] = 1'b1;
        cyc(5);
        check("mask_normal", 32'(mode), 32'(AP_NORMAL));

        // Reset mid-HOLD
        ch_rx_problem[0] = 1'b1;
        cyc(3);
        check("pre_rst_hold", 32'(mode), 32'(AP_HOLD));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_mode", 32'(mode), 32'(AP_INIT));
        check("async_rst_out", 32'(ch_out), 32'h0);
        check("async_rst_fs", 32'(failsafe), 32'd1);
        ch_rx_problem = '0;
        ch_enable = 4'b1111;
        cyc(2);
        rst_n = 1'b1;
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
